store_monitor: RTL and testbench
================================

# store_monitor

Synthesizable store-traffic monitor that sits directly downstream of the multicycle ARM `top` and consumes its memory-write port (`MemWrite`, `Adr`, `WriteData`). It issues a sticky pass/fail verdict in hardware against a programmed pass store and an allowed store address. It also records every observed store in a small first-word-fall-through trace FIFO that a host or bench drains with a valid/ready handshake. This lets the program-completion check run on FPGA as well as in simulation.

## Interface
- `DEPTH`, 8 — trace FIFO entries; power of two, ≥2.
- `PASS_ADR`, 100 — store address that, with `PASS_DATA`, signals success.
- `PASS_DATA`, 7 — data value required at `PASS_ADR`.
- `ALLOW_ADR`, 96 — the only address that may be written without ending the run.
- `TIMEOUT_CYCLES`, 1000 — watchdog limit; used only when `STORE_MON_TIMEOUT_EN` is defined.
- `clk` in 1 — single clock; all state updates on the rising edge.
- `reset` in 1 — synchronous, active-high reset.
- `MemWrite` in 1 — store strobe from `top`.
- `Adr` in 32 — store address from `top`.
- `WriteData` in 32 — store data from `top`.
- `done` out 1 — verdict reached; sticky.
- `pass` out 1 — run ended on the pass store; sticky.
- `fail` out 1 — run ended on a disallowed store or a timeout; sticky.
- `timeout` out 1 — the fail was caused by the watchdog.
- `store_cnt` out 16 — stores observed while in RUN; saturates at 0xFFFF.
- `rd_valid` out 1 — FIFO is non-empty.
- `rd_ready` in 1 — consumer accepts the head entry.
- `rd_adr` out 32 — head entry address; valid only when `rd_valid` is 1.
- `rd_data` out 32 — head entry data; valid only when `rd_valid` is 1.
- `overflow` out 1 — at least one store was dropped because the FIFO was full; sticky.
- `drop_cnt` out 8 — number of dropped stores; saturates at 255.

## Operation
- FSM states:
  - RUN (reset state).
  - PASS (terminal).
  - FAIL (terminal).
- A store is observed on any rising edge with `reset`=0, state RUN and `MemWrite`=1.
- Classification of an observed store:
  - `Adr`==`PASS_ADR` and `WriteData`==`PASS_DATA` → PASS.
  - else `Adr`==`ALLOW_ADR` → stay in RUN.
  - else → FAIL.
  - A store to `PASS_ADR` with wrong data → FAIL.
- Every observed store, including the one that causes the verdict, is pushed to the FIFO as {`Adr`, `WriteData`} and increments `store_cnt`.
- In PASS or FAIL, `MemWrite` is ignored: no push, no count, and the verdict never changes. Only `reset` leaves a terminal state.
- FIFO rules:
  - Pop when `rd_valid` & `rd_ready`.
  - Push when full and no pop in the same cycle → entry dropped, `overflow` set, `drop_cnt` incremented.
  - Push and pop in the same cycle when full → both happen; no drop.
  - Push and pop in the same cycle when empty → push only (no fall-through bypass).
  - `rd_ready` while empty has no effect.
- FIFO draining continues in terminal states.
- Pointers are log2(`DEPTH`)+1 bits wide and wrap modulo 2·`DEPTH`.
  - Full = MSBs differ and low bits equal.
  - Empty = pointers equal.

## Timing
- Reset values:
  - `done`, `pass`, `fail`, `timeout`, `overflow`, `rd_valid` = 0.
  - `store_cnt`, `drop_cnt` = 0.
  - FIFO empty.
  - `rd_adr`, `rd_data` are don't-care.
- Asserting `reset` mid-run flushes the FIFO and clears the verdict on that edge.
- Verdict latency is 1 cycle: a store sampled at edge N makes `done` plus `pass` or `fail` high after edge N.
- `done` = `pass` | `fail` at all times.
- Push latency is 1 cycle: a store sampled at edge N gives `rd_valid`=1 after edge N if the FIFO was empty.
- `rd_adr`/`rd_data` are driven combinationally from the head entry. The next entry appears the cycle after a pop.
- A `MemWrite` held high for k cycles counts as k stores.

## Configuration
- `STORE_MON_TIMEOUT_EN` defined:
  - 32-bit cycle counter, cleared by `reset`, incrementing each cycle in RUN.
  - When it reaches `TIMEOUT_CYCLES` with no verdict → FAIL with `timeout`=1 on that edge.
  - If a store would resolve the verdict on the same edge, the store's verdict wins.
- `STORE_MON_TIMEOUT_EN` undefined: no counter; `timeout` is tied to 0; the run can stay in RUN indefinitely.

## Structure
- Package `store_mon_pkg` contains:
  - FSM state enum `mon_state_t` {RUN, PASS, FAIL}.
  - Trace entry struct `store_entry_t` {adr[31:0], data[31:0]}.
  - Counter width constants.
- Sub-module `store_fifo`:
  - Parameterized by `DEPTH`, storing `store_entry_t`.
  - Ports: push, full, pop, empty, head.
- Top-level `store_monitor` holds the FSM, classification, counters and watchdog.

## Test plan
- Stores (96,0), (96,3), then (100,7) → `pass`=1 one cycle after the third store; `store_cnt`=3; FIFO drains three entries in order.
- Store (104,5) → `fail`=1, `timeout`=0. A later (100,7) store is ignored and `store_cnt` stays at 1.
- Store (100,6) → `fail`=1.
- `DEPTH`=8, `rd_ready`=0, ten stores to 96 → FIFO holds the first 8; `overflow`=1; `drop_cnt`=2.
- FIFO full with `rd_ready`=1 and a store in the same cycle → no drop; occupancy stays 8.
- With `STORE_MON_TIMEOUT_EN` and `TIMEOUT_CYCLES`=50, no stores → `fail`=`timeout`=1 after 50 cycles. Asserting `reset` afterwards returns every output to 0.

Source files
------------

// File: rtl/store_mon_pkg.sv
// Shared types and widths for the store-traffic monitor.
package store_mon_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } mon_state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } store_entry_t;

  localparam int STORE_CNT_W = 16;
  localparam int DROP_CNT_W  = 8;
  localparam int WDOG_W      = 32;

endpackage

// File: rtl/store_fifo.sv
// First-word-fall-through trace FIFO of store_entry_t; full accepts a push only alongside a pop.
module store_fifo
  import store_mon_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  store_entry_t entry,
  output logic         full,
  input  logic         pop,
  output logic         empty,
  output store_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  store_entry_t mem [DEPTH];
  logic         do_pop;
  logic         do_push;

  // One extra pointer bit distinguishes full from empty when the low bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= entry;
  end

endmodule

// File: rtl/store_monitor.sv
// Store-traffic monitor: sticky pass/fail verdict plus store trace FIFO.
// Optional watchdog enabled by defining STORE_MON_TIMEOUT_EN.
module store_monitor
  import store_mon_pkg::*;
#(
  parameter int          DEPTH          = 8,
  parameter logic [31:0] PASS_ADR       = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd7,
  parameter logic [31:0] ALLOW_ADR      = 32'd96,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemWrite,
  input  logic [31:0]            Adr,
  input  logic [31:0]            WriteData,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic                   timeout,
  output logic [STORE_CNT_W-1:0] store_cnt,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [31:0]            rd_adr,
  output logic [31:0]            rd_data,
  output logic                   overflow,
  output logic [DROP_CNT_W-1:0]  drop_cnt
);

  mon_state_t   state;
  store_entry_t head;
  logic         store;
  logic         pass_hit;
  logic         allow_hit;
  logic         resolves;
  logic         full;
  logic         empty;
  logic         wdog_hit;

  assign store     = (state == RUN) & MemWrite;
  assign pass_hit  = (Adr == PASS_ADR) && (WriteData == PASS_DATA);
  assign allow_hit = (Adr == ALLOW_ADR);
  assign resolves  = MemWrite & (pass_hit | ~allow_hit);

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (store),
    .entry ('{adr: Adr, data: WriteData}),
    .full  (full),
    .pop   (rd_ready),
    .empty (empty),
    .head  (head)
  );

  assign rd_valid = ~empty;
  assign rd_adr   = head.adr;
  assign rd_data  = head.data;
  assign pass     = (state == PASS);
  assign fail     = (state == FAIL);
  assign done     = pass | fail;

`ifdef STORE_MON_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog;

  assign wdog_hit = (wdog == TIMEOUT_CYCLES - 1'b1);

  always_ff @(posedge clk) begin
    if (reset)              wdog <= '0;
    else if (state == RUN)  wdog <= wdog + 1'b1;
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wdog_hit           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      timeout   <= 1'b0;
      store_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (store && store_cnt != '1) store_cnt <= store_cnt + 1'b1;
      // A full FIFO only drops when no pop frees a slot on the same edge.
      if (store && full && !rd_ready) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
      if (state == RUN) begin
        if (resolves) begin
          state <= (MemWrite && pass_hit) ? PASS : FAIL;
        end else if (wdog_hit) begin
          state   <= FAIL;
          timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_monitor.sv
// Scoreboard bench for store_monitor: expected trace entries queued on store, compared on drain.
module tb_store_monitor;
  import store_mon_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Adr = '0;
  logic [31:0] WriteData = '0;
  logic        done, pass, fail, timeout, rd_valid, overflow;
  logic        rd_ready = 1'b0;
  logic [15:0] store_cnt;
  logic [31:0] rd_adr, rd_data;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  store_entry_t exp_q[$];
  mon_state_t   exp_state;
  int           exp_cnt;
  int           exp_drop;

  store_monitor #(
    .DEPTH(DEPTH), .PASS_ADR(32'd100), .PASS_DATA(32'd7),
    .ALLOW_ADR(32'd96), .TIMEOUT_CYCLES(32'd50)
  ) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout), .store_cnt(store_cnt),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_adr(rd_adr), .rd_data(rd_data),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference behaviour for one store sampled at the coming edge (pops applied beforehand).
  function automatic void model_store(input logic [31:0] a, input logic [31:0] d);
    if (exp_state != RUN) return;
    if (exp_cnt < 16'hFFFF) exp_cnt++;
    if (exp_q.size() < DEPTH) exp_q.push_back('{adr: a, data: d});
    else if (exp_drop < 255) exp_drop++;
    if (a == 32'd100 && d == 32'd7) exp_state = PASS;
    else if (a != 32'd96) exp_state = FAIL;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; MemWrite = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete(); exp_state = RUN; exp_cnt = 0; exp_drop = 0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemWrite = 1'b1; Adr = a; WriteData = d;
    model_store(a, d);
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic check_verdict(input string name);
    checks++;
    if (pass !== (exp_state == PASS) || fail !== (exp_state == FAIL) || done !== (exp_state != RUN)) begin
      errors++;
      $display("FAIL %s verdict: done=%0b pass=%0b fail=%0b, required state %s", name, done, pass, fail, exp_state.name());
    end
    checks++;
    if (store_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL %s store_cnt: got %0d required %0d", name, store_cnt, exp_cnt);
    end
  endtask

  // Pops every queued entry, comparing each head, then expects the FIFO empty.
  task automatic drain(input string name);
    store_entry_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_adr !== e.adr || rd_data !== e.data) begin
        errors++;
        $display("FAIL %s head: valid=%0b adr=%0d data=%0d required adr=%0d data=%0d",
                 name, rd_valid, rd_adr, rd_data, e.adr, e.data);
      end
      rd_ready = 1'b1;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s empty: rd_valid=%0b required 0", name, rd_valid);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({done, pass, fail, timeout, overflow, rd_valid} !== 6'b0 || store_cnt !== 16'd0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL %s outputs: done=%0b pass=%0b fail=%0b timeout=%0b ovf=%0b valid=%0b cnt=%0d drop=%0d required all 0",
               name, done, pass, fail, timeout, overflow, rd_valid, store_cnt, drop_cnt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_idle("reset");
    do_store(32'd96, 32'd1);
    do_store(32'd104, 32'd2);
    check_verdict("pre_mid_reset");
    do_reset();
    check_idle("mid_reset");
  endtask

  task automatic test_pass();
    do_reset();
    do_store(32'd96, 32'd0);
    do_store(32'd96, 32'd3);
    check_verdict("pass_before");
    do_store(32'd100, 32'd7);
    check_verdict("pass_after");
    drain("pass_drain");
    do_store(32'd104, 32'd1);
    check_verdict("pass_sticky");
    drain("pass_ignored");
  endtask

  task automatic test_fail();
    do_reset();
    do_store(32'd104, 32'd5);
    check_verdict("fail_adr");
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL fail_adr timeout: got %0b required 0", timeout); end
    do_store(32'd100, 32'd7);
    check_verdict("fail_sticky");
    drain("fail_drain");
    do_reset();
    do_store(32'd100, 32'd6);
    check_verdict("fail_data");
    drain("fail_data_drain");
  endtask

  task automatic test_overflow();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      MemWrite = 1'b1; Adr = 32'd96; WriteData = 32'(i + 20);
      model_store(32'd96, 32'(i + 20));
      @(negedge clk);
    end
    MemWrite = 1'b0;
    check_verdict("ovf");
    checks++;
    if (overflow !== 1'b1 || drop_cnt !== 8'(exp_drop) || exp_drop != 2) begin
      errors++;
      $display("FAIL ovf flags: overflow=%0b drop_cnt=%0d required 1 and 2", overflow, drop_cnt);
    end
    drain("ovf_drain");
  endtask

  task automatic test_full_push_pop();
    store_entry_t e;
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_store(32'd96, 32'(i + 40));
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rd_adr !== e.adr || rd_data !== e.data) begin
      errors++;
      $display("FAIL full_pp head: adr=%0d data=%0d required %0d %0d", rd_adr, rd_data, e.adr, e.data);
    end
    rd_ready = 1'b1; MemWrite = 1'b1; Adr = 32'd96; WriteData = 32'd77;
    model_store(32'd96, 32'd77);
    @(negedge clk);
    rd_ready = 1'b0; MemWrite = 1'b0;
    checks++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0 || exp_q.size() != DEPTH) begin
      errors++;
      $display("FAIL full_pp drop: overflow=%0b drop_cnt=%0d required 0 0", overflow, drop_cnt);
    end
    check_verdict("full_pp");
    drain("full_pp_drain");
  endtask

  task automatic test_empty_push_pop();
    do_reset();
    @(negedge clk);
    rd_ready = 1'b1; MemWrite = 1'b1; Adr = 32'd96; WriteData = 32'd9;
    model_store(32'd96, 32'd9);
    @(negedge clk);
    rd_ready = 1'b0; MemWrite = 1'b0;
    checks++;
    if (rd_valid !== 1'b1) begin errors++; $display("FAIL empty_pp valid: got %0b required 1", rd_valid); end
    drain("empty_pp_drain");
  endtask

  task automatic test_watchdog();
    do_reset();
    repeat (49) @(negedge clk);
    checks++;
    if (done !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL wdog_early: done=%0b timeout=%0b required 0 0", done, timeout);
    end
    @(negedge clk);
`ifdef STORE_MON_TIMEOUT_EN
    checks++;
    if (fail !== 1'b1 || timeout !== 1'b1 || done !== 1'b1 || pass !== 1'b0) begin
      errors++; $display("FAIL wdog_fire: fail=%0b timeout=%0b done=%0b required 1 1 1", fail, timeout, done);
    end
`else
    repeat (20) @(negedge clk);
    checks++;
    if (done !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL wdog_off: done=%0b timeout=%0b required 0 0", done, timeout);
    end
`endif
    do_reset();
    check_idle("wdog_reset");
  endtask

  initial begin
    exp_state = RUN; exp_cnt = 0; exp_drop = 0;
    test_reset();
    test_pass();
    test_fail();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
